// File: rtl/mac_pkg.sv
// MAC array shared constants.
//   MAC_W_ELEMENT : bits per MAC input element
//   MAC_LANES     : lanes per MAC input word
package mac_pkg;

    localparam int unsigned MAC_W_ELEMENT = 8;
    localparam int unsigned MAC_LANES     = 64;

endpackage

// File: rtl/tx_pkg.sv
// Transport types between the fetch path and the MAC array.
//   mac_ifm_port : packed IFM word {data, elem_valid, inter_end, accum_end}
package tx_pkg;

    import mac_pkg::*;

    typedef struct packed {
        logic [MAC_LANES*MAC_W_ELEMENT-1:0] data;
        logic [MAC_LANES-1:0]               elem_valid;
        logic                               inter_end;
        logic                               accum_end;
    } mac_ifm_port;

endpackage

// File: rtl/mac_ifm_packer.sv
// IFM lane packer: gathers IN_LANES-wide element beats into one LANES-wide
// MAC input word with a per-lane valid mask. Words close early on inter/accum
// end markers; unfilled lanes are zero-padded and marked invalid.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   i_valid/i_ready     : input beat handshake
//   i_data, i_keep      : beat elements (element 0 in LSBs) and per-element valid
//   i_inter_end         : beat closes the word (intermediate end)
//   i_accum_end         : beat closes the word (accumulation end, implies inter end)
//   o_valid/o_ready     : output word handshake
//   o_data, o_elem_valid: packed word and per-lane valid
//   o_inter_end         : intermediate end flag
//   o_accum_end         : accumulation end flag
//   o_busy              : assembly buffer holds at least one accepted beat
module mac_ifm_packer
    import mac_pkg::*;
    import tx_pkg::*;
#(
    parameter int unsigned ELEM_W   = MAC_W_ELEMENT,
    parameter int unsigned LANES    = 64,
    parameter int unsigned IN_LANES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    output logic                       i_ready,
    input  logic [IN_LANES*ELEM_W-1:0] i_data,
    input  logic [IN_LANES-1:0]        i_keep,
    input  logic                       i_inter_end,
    input  logic                       i_accum_end,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [LANES*ELEM_W-1:0]    o_data,
    output logic [LANES-1:0]           o_elem_valid,
    output logic                       o_inter_end,
    output logic                       o_accum_end,
    output logic                       o_busy
);

    localparam int unsigned BEATS  = LANES / IN_LANES;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned BEAT_W = IN_LANES * ELEM_W;

    if (IN_LANES == 0 || (LANES % IN_LANES) != 0) begin : g_bad_cfg
        $error("mac_ifm_packer: LANES must be a multiple of IN_LANES");
    end

    logic [CNT_W-1:0]        r_cnt;
    logic [LANES*ELEM_W-1:0] r_buf_data;
    logic [LANES-1:0]        r_buf_keep;
    logic [LANES*ELEM_W-1:0] r_out_data;
    logic [LANES-1:0]        r_out_keep;
    logic                    r_out_valid;
    logic                    r_out_inter;
    logic                    r_out_accum;
    logic                    r_busy;

    logic                    w_accept;
    logic                    w_close;
    logic [LANES*ELEM_W-1:0] w_merge_data;
    logic [LANES-1:0]        w_merge_keep;
    logic [LANES*ELEM_W-1:0] w_mask_data;

    assign i_ready  = !r_out_valid || o_ready;
    assign w_accept = i_valid && i_ready;
    assign w_close  = w_accept &&
                      ((r_cnt == CNT_W'(BEATS - 1)) || i_inter_end || i_accum_end);

    // Buffer with the current beat overlaid. Lanes above the current beat
    // carry a cleared mask, so masking the data by the merged keep both
    // zero-pads them and zeroes keep-0 lanes (stale buffer data never leaks).
    always_comb begin
        w_merge_data = r_buf_data;
        w_merge_keep = r_buf_keep;
        for (int unsigned b = 0; b < BEATS; b++) begin
            if (CNT_W'(b) == r_cnt) begin
                w_merge_data[b*BEAT_W +: BEAT_W]     = i_data;
                w_merge_keep[b*IN_LANES +: IN_LANES] = i_keep;
            end
        end
        w_mask_data = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (w_merge_keep[l]) begin
                w_mask_data[l*ELEM_W +: ELEM_W] = w_merge_data[l*ELEM_W +: ELEM_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_buf_data  <= '0;
            r_buf_keep  <= '0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_valid <= 1'b0;
            r_out_inter <= 1'b0;
            r_out_accum <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (r_out_valid && o_ready) begin
                r_out_valid <= 1'b0;
            end
            // A close in the same cycle as a drain overrides the clear above.
            if (w_accept) begin
                if (w_close) begin
                    r_out_data  <= w_mask_data;
                    r_out_keep  <= w_merge_keep;
                    r_out_inter <= i_inter_end | i_accum_end;
                    r_out_accum <= i_accum_end;
                    r_out_valid <= 1'b1;
                    r_cnt       <= '0;
                    r_buf_keep  <= '0;
                    r_busy      <= 1'b0;
                end else begin
                    r_buf_data  <= w_merge_data;
                    r_buf_keep  <= w_merge_keep;
                    r_cnt       <= r_cnt + 1'b1;
                    r_busy      <= 1'b1;
                end
            end
        end
    end

    assign o_valid = r_out_valid;
    assign o_busy  = r_busy;

    if (ELEM_W == MAC_W_ELEMENT && LANES == MAC_LANES) begin : g_port
        mac_ifm_port w_port;
        assign w_port       = mac_ifm_port'({r_out_data, r_out_keep, r_out_inter, r_out_accum});
        assign o_data       = w_port.data;
        assign o_elem_valid = w_port.elem_valid;
        assign o_inter_end  = w_port.inter_end;
        assign o_accum_end  = w_port.accum_end;
    end else begin : g_raw
        assign o_data       = r_out_data;
        assign o_elem_valid = r_out_keep;
        assign o_inter_end  = r_out_inter;
        assign o_accum_end  = r_out_accum;
    end

endmodule

// File: tb/tb_mac_ifm_packer.sv
module tb_mac_ifm_packer;

    localparam int unsigned ELEM_W   = 8;
    localparam int unsigned LANES    = 64;
    localparam int unsigned IN_LANES = 8;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       i_valid;
    logic                       i_ready;
    logic [IN_LANES*ELEM_W-1:0] i_data;
    logic [IN_LANES-1:0]        i_keep;
    logic                       i_inter_end;
    logic                       i_accum_end;
    logic                       o_valid;
    logic                       o_ready;
    logic [LANES*ELEM_W-1:0]    o_data;
    logic [LANES-1:0]           o_elem_valid;
    logic                       o_inter_end;
    logic                       o_accum_end;
    logic                       o_busy;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [511:0] exp_d;

    always #5 clk = ~clk;

    mac_ifm_packer #(
        .ELEM_W  (ELEM_W),
        .LANES   (LANES),
        .IN_LANES(IN_LANES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .i_data      (i_data),
        .i_keep      (i_keep),
        .i_inter_end (i_inter_end),
        .i_accum_end (i_accum_end),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .o_elem_valid(o_elem_valid),
        .o_inter_end (o_inter_end),
        .o_accum_end (o_accum_end),
        .o_busy      (o_busy)
    );

    function automatic logic [63:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until accepted (bounded), then drop i_valid.
    task automatic beat(input logic [63:0] d, input logic [7:0] k,
                        input logic ie, input logic ae);
        int unsigned n;
        n = 0;
        i_valid     = 1'b1;
        i_data      = d;
        i_keep      = k;
        i_inter_end = ie;
        i_accum_end = ae;
        while (!i_ready && n < 20) begin
            tick();
            n++;
        end
        chk("beat_ready", i_ready, 1'b1);
        tick();
        i_valid     = 1'b0;
        i_keep      = '0;
        i_inter_end = 1'b0;
        i_accum_end = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_data = '0; i_keep = '0;
        i_inter_end = 1'b0; i_accum_end = 1'b0; o_ready = 1'b0;
        tick();
        tick();
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_o_data", o_data, '0);
        chk("rst_o_elem_valid", o_elem_valid, '0);
        chk("rst_o_inter_end", o_inter_end, 1'b0);
        chk("rst_o_accum_end", o_accum_end, 1'b0);
        chk("rst_o_busy", o_busy, 1'b0);
        chk("rst_i_ready", i_ready, 1'b1);
        rst = 1'b0;
        o_ready = 1'b1;

        // Full word: lane k holds k/8
        for (int j = 0; j < 8; j++) exp_d[j*64 +: 64] = rep(8'(j));
        for (int b = 0; b < 8; b++) begin
            beat(rep(8'(b)), 8'hFF, 1'b0, 1'b0);
            if (b == 0) chk("full_busy_first", o_busy, 1'b1);
            if (b == 6) chk("full_no_early_valid", o_valid, 1'b0);
        end
        chk("full_o_valid", o_valid, 1'b1);
        chk("full_o_data", o_data, exp_d);
        chk("full_elem_valid", o_elem_valid, {64{1'b1}});
        chk("full_inter_end", o_inter_end, 1'b0);
        chk("full_accum_end", o_accum_end, 1'b0);
        chk("full_busy_after", o_busy, 1'b0);
        tick();
        chk("full_drain", o_valid, 1'b0);

        // Early close on third beat with partial keep
        beat(rep(8'h11), 8'hFF, 1'b0, 1'b0);
        beat(rep(8'h22), 8'hFF, 1'b0, 1'b0);
        beat(rep(8'h33), 8'h0F, 1'b1, 1'b0);
        exp_d = '0;
        exp_d[159:0] = {32'h3333_3333, rep(8'h22), rep(8'h11)};
        chk("early_o_valid", o_valid, 1'b1);
        chk("early_o_data", o_data, exp_d);
        chk("early_elem_valid", o_elem_valid, 64'h0000_0000_000F_FFFF);
        chk("early_inter_end", o_inter_end, 1'b1);
        chk("early_accum_end", o_accum_end, 1'b0);
        tick();

        // Flag-only word
        beat(rep(8'hFF), 8'h00, 1'b0, 1'b1);
        chk("flag_o_valid", o_valid, 1'b1);
        chk("flag_elem_valid", o_elem_valid, '0);
        chk("flag_o_data", o_data, '0);
        chk("flag_inter_end", o_inter_end, 1'b1);
        chk("flag_accum_end", o_accum_end, 1'b1);
        chk("flag_busy", o_busy, 1'b0);
        tick();

        // Back-pressure: word 1 held while word 2 is offered
        for (int j = 0; j < 8; j++) exp_d[j*64 +: 64] = rep(8'(8'h40 + j));
        for (int b = 0; b < 8; b++) beat(rep(8'(8'h40 + b)), 8'hFF, 1'b0, 1'b0);
        chk("bp_w1_valid", o_valid, 1'b1);
        chk("bp_w1_data", o_data, exp_d);
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = rep(8'h50);
        i_keep  = 8'hFF;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("bp_stall_i_ready", i_ready, 1'b0);
            chk("bp_stall_o_valid", o_valid, 1'b1);
            chk("bp_stall_o_data", o_data, exp_d);
        end
        o_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        chk("bp_release_drain", o_valid, 1'b0);
        chk("bp_release_busy", o_busy, 1'b1);
        for (int b = 1; b < 8; b++) beat(rep(8'(8'h50 + b)), 8'hFF, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++) exp_d[j*64 +: 64] = rep(8'(8'h50 + j));
        chk("bp_w2_valid", o_valid, 1'b1);
        chk("bp_w2_data", o_data, exp_d);
        chk("bp_w2_elem_valid", o_elem_valid, {64{1'b1}});
        tick();
        chk("bp_no_dup", o_valid, 1'b0);

        // Back-to-back: 4 words, 32 beats, no bubbles
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 8; b++) begin
                chk("b2b_i_ready", i_ready, 1'b1);
                beat(rep(8'(w*16 + b)), 8'hFF, 1'b0, 1'b0);
                chk("b2b_o_valid_slot", o_valid, (b == 7));
                if (b == 7) begin
                    for (int j = 0; j < 8; j++) exp_d[j*64 +: 64] = rep(8'(w*16 + j));
                    chk("b2b_o_data", o_data, exp_d);
                end
            end
        end
        tick();

        // Reset mid-word
        for (int b = 0; b < 4; b++) beat(rep(8'h99), 8'hFF, 1'b0, 1'b0);
        chk("rstmid_busy_before", o_busy, 1'b1);
        rst = 1'b1;
        tick();
        chk("rstmid_o_valid", o_valid, 1'b0);
        chk("rstmid_o_data", o_data, '0);
        chk("rstmid_elem_valid", o_elem_valid, '0);
        chk("rstmid_inter_end", o_inter_end, 1'b0);
        chk("rstmid_accum_end", o_accum_end, 1'b0);
        chk("rstmid_busy", o_busy, 1'b0);
        rst = 1'b0;
        for (int b = 0; b < 8; b++) begin
            beat(rep(8'(8'h60 + b)), (b < 4) ? 8'h0F : 8'hFF, 1'b0, 1'b0);
        end
        for (int j = 0; j < 8; j++) begin
            if (j < 4) exp_d[j*64 +: 64] = {32'h0, {4{8'(8'h60 + j)}}};
            else       exp_d[j*64 +: 64] = rep(8'(8'h60 + j));
        end
        chk("rstmid_new_valid", o_valid, 1'b1);
        chk("rstmid_new_data", o_data, exp_d);
        chk("rstmid_new_elem_valid", o_elem_valid, 64'hFFFF_FFFF_0F0F_0F0F);
        chk("rstmid_new_inter", o_inter_end, 1'b0);
        chk("rstmid_new_accum", o_accum_end, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_ifm_packer.md
# mac_ifm_packer

Parametrised IFM lane packer in front of the MAC array. It gathers narrow element beats from the IFM fetch path into one LANES-wide MAC input word with a per-lane valid mask. It closes words early on inter/accum end markers, zero-pads unfilled lanes and forwards the end flags. With default parameters its output word matches the packed `mac_ifm_port` layout used by the MAC array, generalising the fixed 64-lane port to any lane count and beat width.

## Interface
- `ELEM_W`, default `MAC_W_ELEMENT`: bits per element.
- `LANES`, default 64: output lanes per MAC word.
- `IN_LANES`, default 8: elements per input beat. Must divide `LANES`. `BEATS = LANES/IN_LANES`.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `i_valid` in 1: input beat valid.
- `i_ready` out 1: input beat accepted when `i_valid && i_ready`.
- `i_data` in `IN_LANES*ELEM_W`: elements; element 0 is in the LSBs.
- `i_keep` in `IN_LANES`: per-element valid.
- `i_inter_end` in 1: this beat closes the word; intermediate end.
- `i_accum_end` in 1: this beat closes the word; accumulation end. Implies inter end.
- `o_valid` out 1: output word valid.
- `o_ready` in 1: downstream accepts the word.
- `o_data` out `LANES*ELEM_W`: packed word.
- `o_elem_valid` out `LANES`: per-lane valid.
- `o_inter_end` out 1: intermediate end flag.
- `o_accum_end` out 1: accumulation end flag.
- `o_busy` out 1: assembly buffer holds at least one accepted beat.

## Operation
- Beat counter `cnt` runs 0..`BEATS-1`. An accepted beat writes lanes `[cnt*IN_LANES +: IN_LANES]` of the assembly buffer: data, plus `i_keep` into the valid mask.
- Closing beat: an accepted beat with `cnt==BEATS-1`, `i_inter_end`, or `i_accum_end`.
- On a closing beat:
  - The merged word moves to the output register.
  - Lanes above the current beat have data 0 and valid 0.
  - `o_inter_end = i_inter_end | i_accum_end`; `o_accum_end = i_accum_end`.
  - `cnt` returns to 0 and the assembly buffer valid mask clears.
- A non-closing beat increments `cnt`.
- A full word with no marker emits with both end flags 0.
- Marker on the first beat with `i_keep==0`: emits an all-invalid word carrying the flags. This is a legal flag-only word.
- Data of lanes with keep 0 is forced to 0 in `o_data`.
- `i_ready = !o_valid || o_ready`. No combinational path from `i_*` to `i_ready`.
- Output register holds its value and flags stable while `o_valid && !o_ready`.
- Reset, at any time:
  - `cnt=0`, `o_valid=0`, `o_data=0`, `o_elem_valid=0`, `o_inter_end=0`, `o_accum_end=0`, `o_busy=0`.
  - A partial word is discarded and the word in the output register is dropped.

## Timing
- Latency: a closing beat accepted at edge N gives `o_valid=1` with the word from N+1.
- Throughput: one beat per cycle while `o_ready` stays high. A word takes `BEATS` cycles with no bubbles.
- Simultaneous drain and close: `o_valid && o_ready` at the same edge as an accepted closing beat. The new word replaces the old one and `o_valid` stays 1.
- Drain without a close: `o_valid` falls at the next edge.
- Back-pressure: while `o_valid && !o_ready`, `i_ready=0` and the buffer and `cnt` are frozen. A stall mid-word never corrupts partial lanes.
- `o_busy` is registered: 1 from the edge after the first beat of a word until the edge after its closing beat.

## Structure
- `mac_pkg` gains `MAC_LANES=64`.
- `tx_pkg` keeps `mac_ifm_port`. At default parameters the top casts `{o_data,o_elem_valid,o_inter_end,o_accum_end}` to `mac_ifm_port`.
- Elaboration assertion: `LANES % IN_LANES == 0`.
- No sub-module. The assembly buffer, counter and output register live inline.

## Test plan
Bench parameters: `ELEM_W=8`, `LANES=64`, `IN_LANES=8`.
- **Full word:** 8 beats, `i_data` = beat index replicated, `i_keep=8'hFF`, `o_ready=1`. Expect one word, lane k = k/8, `o_elem_valid` all ones, flags 0, `o_valid` the cycle after beat 8.
- **Early close:** 3 beats, third with `i_inter_end=1`, `i_keep=8'h0F`. Expect `o_elem_valid = 64'h0000_0000_000F_FFFF`, lanes 20..63 data 0, `o_inter_end=1`, `o_accum_end=0`.
- **Flag-only word:** single beat with `i_accum_end=1`, `i_keep=0`. Expect `o_elem_valid=0`, `o_inter_end=1`, `o_accum_end=1`.
- **Back-pressure:** `o_ready=0` for 5 cycles after word 1 while 8 more beats are offered. Expect `i_ready=0` and `o_data` stable during the stall. Word 2 arrives intact after release, with no lost or duplicated beats.
- **Back-to-back:** 32 beats with `o_ready=1` throughout. Expect 4 words on consecutive 8-cycle slots and `i_ready` constantly 1.
- **Reset mid-word:** `rst` after 4 beats. Expect all outputs 0 the next cycle. The next 8 beats form a clean word with no stale lanes.
